// File: rtl/shift_right_iter.sv
// Iterative 32-bit right shifter: one log-stage per cycle, fixed 5-cycle latency.
// Optional rotate mode enabled by defining SHIFT_RIGHT_ROTATE_EN.
module shift_right_iter #(
   parameter int N = 32
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] in_data,
   input  logic [4:0]   in_shift,
   input  logic [1:0]   in_op,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] out_data
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t       r_state;
   state_t       w_next;
   logic [N-1:0] r_data;
   logic [4:0]   r_shift;
   logic [2:0]   r_k;
   logic         r_sign;
   logic [5:0]   w_amt;
   logic [N-1:0] w_lsr;
   logic [N-1:0] w_hi;
   logic [N-1:0] w_stage;
   logic         w_accept;
`ifdef SHIFT_RIGHT_ROTATE_EN
   logic         r_rot;
   logic [N-1:0] w_wrap;
`endif

   assign w_accept = (r_state == S_IDLE) && in_valid;
   assign w_amt    = 6'd1 << r_k;
   assign w_lsr    = r_data >> w_amt;
   assign w_hi     = ~({N{1'b1}} >> w_amt);
   assign out_data = r_data;

`ifdef SHIFT_RIGHT_ROTATE_EN
   assign w_wrap = r_data << (6'd32 - w_amt);
`endif

   // Stage result: sign fill is zero unless the op was arithmetic.
   always_comb begin
      w_stage = w_lsr | (w_hi & {N{r_sign}});
`ifdef SHIFT_RIGHT_ROTATE_EN
      if (r_rot) w_stage = w_lsr | w_wrap;
`endif
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   // Next-state logic: five SHIFT cycles regardless of shift amount.
   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_IDLE:  if (in_valid)      w_next = S_SHIFT;
         S_SHIFT: if (r_k == 3'd4)   w_next = S_DONE;
         S_DONE:  if (out_ready)     w_next = S_IDLE;
         default:                    w_next = S_IDLE;
      endcase
   end

   // Handshake outputs decoded from state.
   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      if (r_state == S_IDLE) in_ready  = 1'b1;
      if (r_state == S_DONE) out_valid = 1'b1;
   end

   // Datapath: latch operands on accept, apply stage k each SHIFT cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_data  <= '0;
         r_shift <= '0;
         r_k     <= '0;
         r_sign  <= 1'b0;
`ifdef SHIFT_RIGHT_ROTATE_EN
         r_rot   <= 1'b0;
`endif
      end else if (w_accept) begin
         r_data  <= in_data;
         r_shift <= in_shift;
         r_k     <= '0;
         r_sign  <= (in_op == 2'b01) & in_data[N-1];
`ifdef SHIFT_RIGHT_ROTATE_EN
         r_rot   <= (in_op == 2'b10);
`endif
      end else if (r_state == S_SHIFT) begin
         if (r_shift[r_k]) r_data <= w_stage;
         r_k <= r_k + 3'd1;
      end
   end

endmodule
